// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V control FSM.
// States, opcodes and the control-vector bundle live here.
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_FN  = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    typedef struct packed {
        logic       pc_en;
        logic       s0;
        logic       branch;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
    } ctrl_t;

    function automatic logic op_valid(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE,
                          OP_BRANCH, OP_JAL, OP_LUI};
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Datapath-facing bundle of the control FSM.
// master = control FSM, slave = datapath / memory side.
interface multicycle_control_if;

    logic [31:0] instr;
    logic        alu_zero;
    logic        mem_ready;

    logic        ir_load;
    logic        pc_en;
    logic        s0;
    logic        branch;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic        illegal;

    modport master (
        input  instr, alu_zero, mem_ready,
        output ir_load, pc_en, s0, branch, reg_write,
        output mem_read, mem_write, alu_src, alu_op,
        output wb_sel, state, illegal
    );

    modport slave (
        output instr, alu_zero, mem_ready,
        input  ir_load, pc_en, s0, branch, reg_write,
        input  mem_read, mem_write, alu_src, alu_op,
        input  wb_sel, state, illegal
    );

endinterface

// File: rtl/control_decode.sv
// Combinational map from (state, latched opcode) to the control vector.
// Purely a function of registered values, so the outputs are glitch-free.
module control_decode
    import multicycle_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    output ctrl_t      ctrl
);

    logic is_r;
    logic is_i;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_lui;

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_lui    = (opcode == OP_LUI);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_EXEC: begin
                unique case (1'b1)
                    is_r: begin
                        ctrl.alu_op = ALU_FN;
                    end
                    is_i: begin
                        ctrl.alu_op  = ALU_FN;
                        ctrl.alu_src = 1'b1;
                    end
                    is_load, is_store: begin
                        ctrl.alu_op  = ALU_ADD;
                        ctrl.alu_src = 1'b1;
                    end
                    is_branch: begin
                        ctrl.alu_op = ALU_SUB;
                        ctrl.branch = 1'b1;
                        ctrl.pc_en  = 1'b1;
                    end
                    is_jal: begin
                        ctrl.s0 = 1'b1;
                    end
                    default: ;
                endcase
            end
            // Address operands stay selected while memory is busy.
            S_MEM: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_read  = is_load;
                ctrl.mem_write = is_store;
            end
            S_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.pc_en     = 1'b1;
                unique case (1'b1)
                    is_r: begin
                        ctrl.alu_op = ALU_FN;
                        ctrl.wb_sel = WB_ALU;
                    end
                    is_i: begin
                        ctrl.alu_op  = ALU_FN;
                        ctrl.alu_src = 1'b1;
                        ctrl.wb_sel  = WB_ALU;
                    end
                    is_load: begin
                        ctrl.wb_sel = WB_MEM;
                    end
                    is_jal: begin
                        ctrl.s0     = 1'b1;
                        ctrl.wb_sel = WB_PC4;
                    end
                    is_lui: begin
                        ctrl.wb_sel = WB_IMM;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with MEM timeout trap.
// Optional cycle/retired counters when PERF_CNT_EN is defined.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT      = 15,
    parameter int unsigned RESET_STATE_HOLD = 1
) (
    input logic                  sysclk,
    input logic                  reset,
    multicycle_control_if.master bus
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]          cycle_cnt,
    output logic [31:0]          retired_cnt
`endif
);

    localparam logic [7:0] TMO_LAST  = 8'(MEM_TIMEOUT - 1);
    localparam logic [1:0] HOLD_INIT = 2'(RESET_STATE_HOLD);

    state_t     state_q;
    state_t     state_d;
    logic [6:0] op_q;
    logic [2:0] f3_q;
    logic [1:0] hold_q;
    logic [1:0] hold_d;
    logic [7:0] tmo_q;
    logic [7:0] tmo_d;
    logic       illegal_q;
    logic       illegal_d;
    logic       ir_load;
    logic       store_done;
    ctrl_t      ctrl;
    logic       unused_bits;

    assign ir_load = (state_q == S_FETCH) && (hold_q == 2'd0);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        tmo_d     = tmo_q;
        illegal_d = illegal_q;
        unique case (state_q)
            S_FETCH: begin
                if (hold_q != 2'd0) begin
                    hold_d = hold_q - 2'd1;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_valid(op_q)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (op_q == OP_BRANCH) begin
                    state_d = S_FETCH;
                end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            // A late mem_ready on the final allowed cycle still completes.
            S_MEM: begin
                if (bus.mem_ready) begin
                    tmo_d   = '0;
                    state_d = (op_q == OP_STORE) ? S_FETCH : S_WB;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d     = '0;
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_TRAP: ;
            default: begin
                state_d   = S_TRAP;
                illegal_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            hold_q    <= HOLD_INIT;
            tmo_q     <= '0;
            illegal_q <= 1'b0;
            op_q      <= '0;
            f3_q      <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            tmo_q     <= tmo_d;
            illegal_q <= illegal_d;
            if (ir_load) begin
                op_q <= bus.instr[6:0];
                f3_q <= bus.instr[14:12];
            end
        end
    end

    control_decode u_decode (
        .state  (state_q),
        .opcode (op_q),
        .ctrl   (ctrl)
    );

    // A store retires in MEM the cycle memory acknowledges it.
    assign store_done = (state_q == S_MEM) && (op_q == OP_STORE)
                        && bus.mem_ready;

    assign bus.ir_load   = ir_load;
    assign bus.pc_en     = ctrl.pc_en | store_done;
    assign bus.s0        = ctrl.s0;
    assign bus.branch    = ctrl.branch;
    assign bus.reg_write = ctrl.reg_write;
    assign bus.mem_read  = ctrl.mem_read;
    assign bus.mem_write = ctrl.mem_write;
    assign bus.alu_src   = ctrl.alu_src;
    assign bus.alu_op    = ctrl.alu_op;
    assign bus.wb_sel    = ctrl.wb_sel;
    assign bus.state     = state_q;
    assign bus.illegal   = illegal_q;

    assign unused_bits = ^{bus.instr[31:15], bus.instr[11:7],
                           bus.alu_zero, f3_q};

`ifdef PERF_CNT_EN
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else if (state_q != S_TRAP) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (bus.pc_en) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-instruction expected
// records are queued at issue and compared when the instruction ends.
module tb_multicycle_control;

    typedef struct packed {
        logic [7:0] cycles;
        logic [7:0] irl;
        logic [7:0] pcen;
        logic [7:0] memr;
        logic [7:0] memw;
        logic       rw;
        logic       s0;
        logic       br;
        logic [1:0] wb;
        logic [1:0] exop;
        logic       exsrc;
        logic [2:0] endst;
    } rec_t;

    logic sysclk = 1'b0;
    logic reset  = 1'b0;
    int   tests  = 0;
    int   fails  = 0;
    rec_t sb[$];

    multicycle_control_if bus();

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] retired_cnt;
`endif

    multicycle_control #(
        .MEM_TIMEOUT      (15),
        .RESET_STATE_HOLD (1)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .bus         (bus)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
`endif
    );

    always #5 sysclk = ~sysclk;

    function automatic rec_t mk(input int cyc, input int memr,
                                input int memw, input int pcen,
                                input logic rw, input logic [1:0] wb,
                                input logic s0, input logic br,
                                input logic [1:0] op, input logic src,
                                input logic [2:0] st);
        rec_t r;
        r.cycles = 8'(cyc);
        r.irl    = 8'd1;
        r.pcen   = 8'(pcen);
        r.memr   = 8'(memr);
        r.memw   = 8'(memw);
        r.rw     = rw;
        r.s0     = s0;
        r.br     = br;
        r.wb     = wb;
        r.exop   = op;
        r.exsrc  = src;
        r.endst  = st;
        return r;
    endfunction

    function automatic string fmt(input rec_t r);
        return $sformatf({"cyc=%0d irl=%0d pc_en=%0d rd=%0d wr=%0d ",
                          "rw=%b s0=%b br=%b wb=%b op=%b src=%b st=%0d"},
                         r.cycles, r.irl, r.pcen, r.memr, r.memw,
                         r.rw, r.s0, r.br, r.wb, r.exop, r.exsrc,
                         r.endst);
    endfunction

    function automatic logic [15:0] outs();
        return {bus.ir_load, bus.pc_en, bus.s0, bus.branch,
                bus.reg_write, bus.mem_read, bus.mem_write,
                bus.alu_src, bus.alu_op, bus.wb_sel, bus.state,
                bus.illegal};
    endfunction

    // Drives one instruction from FETCH until the FSM is back in
    // FETCH or in TRAP; dly = MEM cycles before mem_ready (-1 never).
    task automatic run_instr(input logic [31:0] w, input logic z,
                             input int dly, input logic noise,
                             output rec_t o);
        int memc;
        bit done;
        o    = '0;
        memc = 0;
        done = 0;
        bus.instr    = w;
        bus.alu_zero = z;
        for (int c = 0; c < 40 && !done; c++) begin
            bus.mem_ready = noise;
            if (bus.state == 3'd3) begin
                bus.mem_ready = (memc == dly);
                memc++;
            end
            #1;
            o.cycles = o.cycles + 8'd1;
            if (bus.ir_load)   o.irl  = o.irl + 8'd1;
            if (bus.mem_read)  o.memr = o.memr + 8'd1;
            if (bus.mem_write) o.memw = o.memw + 8'd1;
            if (bus.state == 3'd2) begin
                o.exop  = bus.alu_op;
                o.exsrc = bus.alu_src;
            end
            if (bus.pc_en) begin
                o.pcen = o.pcen + 8'd1;
                o.rw   = bus.reg_write;
                o.wb   = bus.wb_sel;
                o.s0   = bus.s0;
                o.br   = bus.branch;
            end
            @(negedge sysclk);
            bus.instr = 32'h0;
            if (bus.state == 3'd0 || bus.state == 3'd7) done = 1;
        end
        bus.mem_ready = 1'b0;
        o.endst = bus.state;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
    endtask

    task automatic test_reset();
        bus.instr     = 32'h0;
        bus.alu_zero  = 1'b0;
        bus.mem_ready = 1'b0;
        reset         = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge sysclk);
            tests++;
            if (outs() !== 16'h0) begin
                fails++;
                $display("FAIL reset_outs[%0d] got %h exp 0000", i, outs());
            end
        end
        reset = 1'b1;
        @(negedge sysclk);
        tests++;
        if (bus.ir_load !== 1'b1 || bus.state !== 3'd0) begin
            fails++;
            $display("FAIL reset_hold ir_load=%b state=%0d exp 1/0",
                     bus.ir_load, bus.state);
        end
    endtask

    task automatic test_alu();
        logic [31:0] w[4];
        rec_t        ex[4];
        rec_t        o;
        rec_t        e;
        w[0]  = 32'h002081B3;
        ex[0] = mk(4, 0, 0, 1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 3'd0);
        w[1]  = 32'h00500093;
        ex[1] = mk(4, 0, 0, 1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 3'd0);
        w[2]  = 32'h123450B7;
        ex[2] = mk(4, 0, 0, 1, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0);
        w[3]  = 32'h008000EF;
        ex[3] = mk(4, 0, 0, 1, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(ex[i]);
            run_instr(w[i], 1'b0, -1, (i == 0), o);
            e = sb.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL alu[%0d] got %s exp %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_branch();
        rec_t o;
        rec_t e;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(3, 0, 0, 1, 1'b0, 2'b00, 1'b0, 1'b1,
                            2'b01, 1'b0, 3'd0));
            run_instr(32'h00208463, (i == 0), -1, 1'b0, o);
            e = sb.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL beq[z=%0d] got %s exp %s", (i == 0),
                         fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_load_store();
        logic [31:0] w[3];
        int          d[3];
        rec_t        ex[3];
        rec_t        o;
        rec_t        e;
        w[0] = 32'h0000A103;
        d[0] = 3;
        ex[0] = mk(8, 4, 0, 1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 3'd0);
        w[1] = 32'h0000A103;
        d[1] = 0;
        ex[1] = mk(5, 1, 0, 1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 3'd0);
        w[2] = 32'h0020A023;
        d[2] = 0;
        ex[2] = mk(4, 0, 1, 1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 3'd0);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(ex[i]);
            run_instr(w[i], 1'b0, d[i], 1'b0, o);
            e = sb.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL ldst[%0d] got %s exp %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        bus.instr     = 32'h0000A103;
        bus.mem_ready = 1'b0;
        for (int c = 0; c < 10 && bus.state != 3'd3; c++) begin
            @(negedge sysclk);
        end
        tests++;
        if (bus.state !== 3'd3 || bus.mem_read !== 1'b1) begin
            fails++;
            $display("FAIL midmem_enter state=%0d rd=%b exp 3/1",
                     bus.state, bus.mem_read);
        end
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
        tests++;
        if (bus.state !== 3'd0 || bus.mem_read !== 1'b0) begin
            fails++;
            $display("FAIL midmem_reset state=%0d rd=%b exp 0/0",
                     bus.state, bus.mem_read);
        end
        reset = 1'b1;
        bus.instr = 32'h0;
        @(negedge sysclk);
        tests++;
        if (bus.ir_load !== 1'b1) begin
            fails++;
            $display("FAIL midmem_rehold ir_load=%b exp 1", bus.ir_load);
        end
    endtask

    task automatic test_timeout();
        rec_t o;
        rec_t e;
        sb.push_back(mk(18, 0, 15, 1, 1'b0, 2'b00, 1'b0, 1'b0,
                        2'b00, 1'b1, 3'd0));
        run_instr(32'h0020A023, 1'b0, 14, 1'b0, o);
        e = sb.pop_front();
        tests++;
        if (o !== e) begin
            fails++;
            $display("FAIL tmo_late_ready got %s exp %s", fmt(o), fmt(e));
        end
        sb.push_back(mk(18, 0, 15, 0, 1'b0, 2'b00, 1'b0, 1'b0,
                        2'b00, 1'b1, 3'd7));
        run_instr(32'h0020A023, 1'b0, -1, 1'b0, o);
        e = sb.pop_front();
        tests++;
        if (o !== e) begin
            fails++;
            $display("FAIL tmo_trap got %s exp %s", fmt(o), fmt(e));
        end
        tests++;
        if (bus.illegal !== 1'b1 || bus.mem_write !== 1'b0) begin
            fails++;
            $display("FAIL tmo_flags illegal=%b wr=%b exp 1/0",
                     bus.illegal, bus.mem_write);
        end
        bus.mem_ready = 1'b1;
        repeat (3) @(negedge sysclk);
        tests++;
        if (outs() !== 16'h000F) begin
            fails++;
            $display("FAIL trap_absorb got %h exp 000f", outs());
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_illegal();
        rec_t o;
        rec_t e;
        do_reset();
        sb.push_back(mk(2, 0, 0, 0, 1'b0, 2'b00, 1'b0, 1'b0,
                        2'b00, 1'b0, 3'd7));
        run_instr(32'hFFFFFFFF, 1'b0, -1, 1'b0, o);
        e = sb.pop_front();
        tests++;
        if (o !== e) begin
            fails++;
            $display("FAIL illegal_op got %s exp %s", fmt(o), fmt(e));
        end
        tests++;
        if (bus.illegal !== 1'b1) begin
            fails++;
            $display("FAIL illegal_flag got %b exp 1", bus.illegal);
        end
    endtask

`ifdef PERF_CNT_EN
    task automatic test_perf();
        rec_t o;
        rec_t e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(4, 0, 0, 1, 1'b1, 2'b00, 1'b0, 1'b0,
                            2'b10, 1'b0, 3'd0));
            run_instr(32'h002081B3, 1'b0, -1, 1'b0, o);
            e = sb.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL perf_add[%0d] got %s exp %s", i,
                         fmt(o), fmt(e));
            end
        end
        tests++;
        if (retired_cnt !== 32'd3 || cycle_cnt !== 32'd13) begin
            fails++;
            $display("FAIL perf_cnt retired=%0d cycles=%0d exp 3/13",
                     retired_cnt, cycle_cnt);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_load_store();
        test_reset_mid_mem();
        test_timeout();
        test_illegal();
`ifdef PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
